// File: rtl/vid_pkg.sv
// Shared types and register field positions for the video raster timing stage.
package vid_pkg;

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } phase_t;

  localparam int CR_ENABLE_BIT = 0;

  localparam int H1_ACTIVE_LSB = 0;
  localparam int H1_FRONT_LSB  = 16;
  localparam int H2_SYNC_LSB   = 0;
  localparam int H2_BACK_LSB   = 16;
  localparam int V1_ACTIVE_LSB = 0;
  localparam int V1_FRONT_LSB  = 16;
  localparam int V2_SYNC_LSB   = 0;
  localparam int V2_BACK_LSB   = 16;

  function automatic phase_t next_phase(input phase_t ph);
    case (ph)
      PH_ACTIVE: return PH_FRONT;
      PH_FRONT:  return PH_SYNC;
      PH_SYNC:   return PH_BACK;
      default:   return PH_ACTIVE;
    endcase
  endfunction

endpackage

// File: rtl/vid_axis_counter.sv
// One raster axis: walks ACTIVE -> FRONT -> SYNC -> BACK, each phase lasting
// its programmed length (a length of 0 behaves as 1).
module vid_axis_counter
  import vid_pkg::*;
#(
  parameter int CW = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clear_i,
  input  logic          advance_i,
  input  logic [CW-1:0] len_active_i,
  input  logic [CW-1:0] len_front_i,
  input  logic [CW-1:0] len_sync_i,
  input  logic [CW-1:0] len_back_i,
  output phase_t        phase_o,
  output logic [CW-1:0] count_o,
  output logic          last_o
);

  phase_t        phase_q, phase_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] len_sel, len_eff;
  logic          at_end;

  always_comb begin
    case (phase_q)
      PH_FRONT: len_sel = len_front_i;
      PH_SYNC:  len_sel = len_sync_i;
      PH_BACK:  len_sel = len_back_i;
      default:  len_sel = len_active_i;
    endcase
    len_eff = (len_sel == '0) ? CW'(1) : len_sel;
    at_end  = (count_q == len_eff - CW'(1));

    phase_d = phase_q;
    count_d = count_q;
    if (clear_i) begin
      phase_d = PH_ACTIVE;
      count_d = '0;
    end else if (advance_i) begin
      if (at_end) begin
        phase_d = next_phase(phase_q);
        count_d = '0;
      end else begin
        count_d = count_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      phase_q <= PH_ACTIVE;
      count_q <= '0;
    end else begin
      phase_q <= phase_d;
      count_q <= count_d;
    end
  end

  assign phase_o = phase_q;
  assign count_o = count_q;
  assign last_o  = (phase_q == PH_BACK) && at_end;

endmodule

// File: rtl/vid_timing_gen.sv
// Raster timing and pixel output stage: generates sync/blank from shadowed
// timing fields and pops one FIFO word per active pixel.
module vid_timing_gen
  import vid_pkg::*;
#(
  parameter int CW    = 16,
  parameter int PIX_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      cr,
  input  logic [31:0]      h1,
  input  logic [31:0]      h2,
  input  logic [31:0]      v1,
  input  logic [31:0]      v2,
  input  logic [PIX_W-1:0] fifo_data,
  input  logic             fifo_empty,
  output logic             fifo_rd,
  output logic             hsync,
  output logic             hblank,
  output logic             vsync,
  output logic             vblank,
  output logic [7:0]       R,
  output logic [7:0]       G,
  output logic [7:0]       B,
  output logic             frame_start,
  output logic             line_done,
  output logic             underrun
);

  logic          enable, en_q, rise, load, frame_end, active;
  logic [CW-1:0] live [8];
  logic [CW-1:0] shd_q [8];
  logic [CW-1:0] cur [8];
  logic [CW-1:0] ha_eff;
  phase_t        h_ph, v_ph;
  logic [CW-1:0] h_cnt, v_cnt;
  logic          h_last, v_last;
  logic          unused_cr;

  assign enable    = cr[CR_ENABLE_BIT];
  assign unused_cr = ^cr[31:1];
  assign rise      = enable & ~en_q;

  assign live[0] = h1[H1_ACTIVE_LSB +: CW];
  assign live[1] = h1[H1_FRONT_LSB  +: CW];
  assign live[2] = h2[H2_SYNC_LSB   +: CW];
  assign live[3] = h2[H2_BACK_LSB   +: CW];
  assign live[4] = v1[V1_ACTIVE_LSB +: CW];
  assign live[5] = v1[V1_FRONT_LSB  +: CW];
  assign live[6] = v2[V2_SYNC_LSB   +: CW];
  assign live[7] = v2[V2_BACK_LSB   +: CW];

  // On the enable cycle the shadows are still stale, so steer live values through.
  always_comb begin
    for (int i = 0; i < 8; i++) cur[i] = rise ? live[i] : shd_q[i];
  end

  assign frame_end = enable & h_last & v_last;
  assign load      = rise | frame_end;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_q <= 1'b0;
      for (int i = 0; i < 8; i++) shd_q[i] <= '0;
    end else begin
      en_q <= enable;
      if (load) begin
        for (int i = 0; i < 8; i++) shd_q[i] <= live[i];
      end
    end
  end

  vid_axis_counter #(.CW(CW)) u_h (
    .clk_i(clk), .rst_i(reset), .clear_i(~enable), .advance_i(enable),
    .len_active_i(cur[0]), .len_front_i(cur[1]), .len_sync_i(cur[2]), .len_back_i(cur[3]),
    .phase_o(h_ph), .count_o(h_cnt), .last_o(h_last)
  );

  vid_axis_counter #(.CW(CW)) u_v (
    .clk_i(clk), .rst_i(reset), .clear_i(~enable), .advance_i(enable & h_last),
    .len_active_i(cur[4]), .len_front_i(cur[5]), .len_sync_i(cur[6]), .len_back_i(cur[7]),
    .phase_o(v_ph), .count_o(v_cnt), .last_o(v_last)
  );

  // FIFO handshake: show-ahead head word is valid while fifo_empty=0; fifo_rd
  // pops it at the next edge and is only raised on an active pixel with data.
  assign active  = enable && (h_ph == PH_ACTIVE) && (v_ph == PH_ACTIVE);
  assign fifo_rd = active & ~fifo_empty;
  assign ha_eff  = (cur[0] == '0) ? CW'(1) : cur[0];

  logic             hsync_q, hblank_q, vsync_q, vblank_q, fs_q, ld_q, und_q;
  logic             hsync_d, hblank_d, vsync_d, vblank_d, fs_d, ld_d, und_d;
  logic [PIX_W-1:0] rgb_q, rgb_d;

  always_comb begin
    hsync_d  = 1'b0;
    hblank_d = 1'b1;
    vsync_d  = 1'b0;
    vblank_d = 1'b1;
    rgb_d    = '0;
    fs_d     = 1'b0;
    ld_d     = 1'b0;
    und_d    = 1'b0;
    if (enable) begin
      hsync_d  = (h_ph == PH_SYNC);
      hblank_d = (h_ph != PH_ACTIVE);
      vsync_d  = (v_ph == PH_SYNC);
      vblank_d = (v_ph != PH_ACTIVE);
      if (active && !fifo_empty) rgb_d = fifo_data;
      fs_d  = (v_ph == PH_SYNC) && (v_cnt == '0) && (h_ph == PH_ACTIVE) && (h_cnt == '0);
      ld_d  = active && (h_cnt == ha_eff - CW'(1));
      und_d = und_q | (active & fifo_empty);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync_q  <= 1'b0;
      hblank_q <= 1'b1;
      vsync_q  <= 1'b0;
      vblank_q <= 1'b1;
      rgb_q    <= '0;
      fs_q     <= 1'b0;
      ld_q     <= 1'b0;
      und_q    <= 1'b0;
    end else begin
      hsync_q  <= hsync_d;
      hblank_q <= hblank_d;
      vsync_q  <= vsync_d;
      vblank_q <= vblank_d;
      rgb_q    <= rgb_d;
      fs_q     <= fs_d;
      ld_q     <= ld_d;
      und_q    <= und_d;
    end
  end

  assign hsync       = hsync_q;
  assign hblank      = hblank_q;
  assign vsync       = vsync_q;
  assign vblank      = vblank_q;
  assign R           = rgb_q[23:16];
  assign G           = rgb_q[15:8];
  assign B           = rgb_q[7:0];
  assign frame_start = fs_q;
  assign line_done   = ld_q;
  assign underrun    = und_q;

endmodule

// File: tb/tb_vid_timing_gen.sv
// Bench for vid_timing_gen: frame-position reference model plus directed
// timing, underrun, reprogram, abort and zero-field scenarios, then random runs.
module tb_vid_timing_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cr, h1, h2, v1, v2;
  logic [23:0] fifo_data;
  logic        fifo_empty;
  logic        fifo_rd, hsync, hblank, vsync, vblank, frame_start, line_done, underrun;
  logic [7:0]  R, G, B;

  always #5 clk = ~clk;

  vid_timing_gen dut (
    .clk(clk), .reset(reset), .cr(cr), .h1(h1), .h2(h2), .v1(v1), .v2(v2),
    .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd),
    .hsync(hsync), .hblank(hblank), .vsync(vsync), .vblank(vblank),
    .R(R), .G(G), .B(B), .frame_start(frame_start), .line_done(line_done),
    .underrun(underrun)
  );

  logic [30:0] obs_vec;
  assign obs_vec = {hsync, hblank, vsync, vblank, frame_start, line_done, underrun, R, G, B};
  localparam logic [30:0] RST_VEC = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0};

  int checks = 0;
  int passes = 0;

  // reference model state: frame parameters latched at frame start, position in frame
  int unsigned mh[4];
  int unsigned mv[4];
  int unsigned m_p = 0;
  bit          m_run = 0;
  bit          m_und = 0;
  int unsigned pix_k = 0;
  bit          force_empty = 0;
  bit          inj_under = 0;
  int          cyc = 0;
  int          rd_cnt = 0, fs_cnt = 0;
  int          last_hs_rise = -1, hs_period = 0;
  bit          hs_prev = 0;
  logic [23:0] exp_word;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int unsigned eff(input logic [15:0] v);
    return (v == 16'd0) ? 1 : int'(v);
  endfunction

  function automatic int unsigned ph_of(input int unsigned pos, input int unsigned a,
                                        input int unsigned f, input int unsigned s);
    if (pos < a) return 0;
    if (pos < a + f) return 1;
    if (pos < a + f + s) return 2;
    return 3;
  endfunction

  function automatic logic [23:0] word_of(input int unsigned k);
    return {8'(3 * k + 1), 8'(3 * k + 2), 8'(3 * k + 3)};
  endfunction

  task automatic load_params();
    mh[0] = eff(h1[15:0]); mh[1] = eff(h1[31:16]);
    mh[2] = eff(h2[15:0]); mh[3] = eff(h2[31:16]);
    mv[0] = eff(v1[15:0]); mv[1] = eff(v1[31:16]);
    mv[2] = eff(v2[15:0]); mv[3] = eff(v2[31:16]);
  endtask

  task automatic set_timing(input int ha, input int hf, input int hs, input int hb,
                            input int va, input int vf, input int vs, input int vb);
    h1 = {16'(hf), 16'(ha)};
    h2 = {16'(hb), 16'(hs)};
    v1 = {16'(vf), 16'(va)};
    v2 = {16'(vb), 16'(vs)};
  endtask

  // One clock cycle: drive inputs, check fifo_rd mid-cycle, check registered outputs after the edge.
  task automatic step();
    bit          en, act, emp, rd_seen;
    int unsigned len_l, len_f, line, x, hp, vp;
    logic [30:0] exp_v;
    logic [23:0] word;
    en = cr[0];
    word = word_of(pix_k);
    fifo_data = word;
    exp_v = RST_VEC;
    act = 0;
    len_l = 0;
    len_f = 0;
    if (en && !m_run) begin
      load_params();
      m_p = 0;
      m_run = 1;
    end
    emp = force_empty || (inj_under && en && m_p == 10);
    fifo_empty = emp;
    if (en) begin
      len_l = mh[0] + mh[1] + mh[2] + mh[3];
      len_f = len_l * (mv[0] + mv[1] + mv[2] + mv[3]);
      line = m_p / len_l;
      x = m_p % len_l;
      hp = ph_of(x, mh[0], mh[1], mh[2]);
      vp = ph_of(line, mv[0], mv[1], mv[2]);
      act = (hp == 0) && (vp == 0);
      if (act && emp) m_und = 1;
      exp_v = {hp == 2, hp != 0, vp == 2, vp != 0, m_p == (mv[0] + mv[1]) * len_l,
               act && (x == mh[0] - 1), m_und, (act && !emp) ? word : 24'h0};
    end else begin
      m_run = 0;
      m_und = 0;
    end
    @(negedge clk);
    check("fifo_rd", 64'(fifo_rd), 64'(act && !emp));
    rd_seen = fifo_rd;
    @(posedge clk);
    #1;
    cyc++;
    check("outputs", 64'(obs_vec), 64'(exp_v));
    if (rd_seen) begin
      pix_k++;
      rd_cnt++;
    end
    if (frame_start) fs_cnt++;
    if (hsync && !hs_prev) begin
      if (last_hs_rise >= 0) hs_period = cyc - last_hs_rise;
      last_hs_rise = cyc;
    end
    hs_prev = hsync;
    if (en) begin
      m_p++;
      if (m_p == len_f) begin
        m_p = 0;
        load_params();
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  initial begin
    reset = 1'b1;
    cr = 32'h0;
    set_timing(4, 1, 2, 1, 3, 1, 1, 1);
    fifo_data = 24'h0;
    fifo_empty = 1'b1;
    #12;
    check("reset_vec", 64'(obs_vec), 64'(RST_VEC));
    check("reset_rd", 64'(fifo_rd), 64'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    run(3);

    // basic timing and pixel order
    cr = 32'h1;
    rd_cnt = 0; fs_cnt = 0; last_hs_rise = -1;
    step();
    check("first_pixel", 64'({hblank, vblank, R, G, B}), 64'({2'b00, 24'h010203}));
    run(47);
    check("rd_per_frame1", 64'(rd_cnt), 64'(12));
    check("fs_per_frame1", 64'(fs_cnt), 64'(1));
    check("line_period", 64'(hs_period), 64'(8));
    rd_cnt = 0; fs_cnt = 0;
    run(48);
    check("rd_per_frame2", 64'(rd_cnt), 64'(12));
    check("fs_per_frame2", 64'(fs_cnt), 64'(1));

    // underrun on pixel 2 of line 1, sticky until enable drops
    inj_under = 1;
    run(48);
    inj_under = 0;
    check("underrun_set", 64'(underrun), 64'(1));
    run(20);
    check("underrun_sticky", 64'(underrun), 64'(1));
    cr = 32'h0;
    step();
    check("underrun_clear", 64'(underrun), 64'(0));

    // restart, then reprogram hactive 4->6 during line 1
    cr = 32'h1;
    step();
    check("restart_pos0", 64'({hblank, vblank}), 64'(0));
    run(9);
    h1 = {16'd1, 16'd6};
    last_hs_rise = -1;
    run(38);
    check("old_line_period", 64'(hs_period), 64'(8));
    run(60);
    check("new_line_period", 64'(hs_period), 64'(10));

    // abort by dropping enable on line 2
    run(20);
    cr = 32'h0;
    step();
    check("abort_vec", 64'({hblank, vblank, R, G, B}), 64'({2'b11, 24'h0}));
    run(3);
    cr = 32'h1;
    exp_word = word_of(pix_k);
    step();
    check("abort_restart", 64'({hblank, vblank, R, G, B}), 64'({2'b00, exp_word}));

    // asynchronous reset mid-line
    run(5);
    reset = 1'b1;
    #2;
    check("async_reset", 64'(obs_vec), 64'(RST_VEC));
    m_run = 0;
    m_und = 0;
    #1;
    reset = 1'b0;
    run(60);

    // zero hfront and zero vsync behave as length 1
    cr = 32'h0;
    step();
    set_timing(4, 0, 2, 1, 3, 1, 0, 1);
    cr = 32'h1;
    fs_cnt = 0; last_hs_rise = -1;
    run(48);
    check("zero_line_period", 64'(hs_period), 64'(8));
    check("zero_frame_fs", 64'(fs_cnt), 64'(1));

    // randomized programming, FIFO starvation, reprogram and aborts
    for (int it = 0; it < 8; it++) begin
      int n, chg, drop;
      cr = 32'h0;
      step();
      set_timing($urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 2),
                 $urandom_range(0, 2), $urandom_range(0, 2));
      cr = 32'h1;
      n = $urandom_range(80, 250);
      chg = $urandom_range(0, n - 1);
      drop = $urandom_range(0, n - 1);
      for (int s = 0; s < n; s++) begin
        force_empty = ($urandom_range(0, 9) == 0);
        if (s == chg) h1 = {16'($urandom_range(0, 3)), 16'($urandom_range(0, 5))};
        if (s == drop) cr = 32'h0;
        if (s == drop + 2) cr = 32'h1;
        step();
      end
      force_empty = 0;
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/vid_timing_gen.md
# vid_timing_gen

Raster timing and pixel-output stage of the video controller, directly downstream of the pixel FIFO. Generates hsync/hblank/vsync/vblank from the programmed h1/h2/v1/v2 registers. Pops one 24-bit RGB word from the FIFO per active pixel and drives R/G/B aligned to the blanking outputs. Emits frame and line events to the upstream fetch engine.

## Interface
Parameters:
- CW, 16, width of each timing field and of both counters
- PIX_W, 24, FIFO word width, packed {R[23:16], G[15:8], B[7:0]}

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- cr  in  32  control register; bit 0 = video enable
- h1  in  32  [15:0] hactive, [31:16] hfront
- h2  in  32  [15:0] hsync width, [31:16] hback
- v1  in  32  [15:0] vactive (lines), [31:16] vfront
- v2  in  32  [15:0] vsync width, [31:16] vback
- fifo_data  in  PIX_W  show-ahead FIFO head word, valid when fifo_empty=0
- fifo_empty  in  1  FIFO empty flag
- fifo_rd  out  1  pop request, combinational
- hsync, hblank, vsync, vblank  out  1 each  registered raster controls, active-high
- R, G, B  out  8 each  registered pixel outputs
- frame_start  out  1  one-cycle pulse, first cycle of vertical sync
- line_done  out  1  one-cycle pulse on the last active pixel of each active line
- underrun  out  1  sticky FIFO-underrun flag

## Operation
- Reset values: hsync=0, vsync=0, hblank=1, vblank=1, R=G=B=0, frame_start=0, line_done=0, underrun=0. Counters are 0 at reset; fifo_rd=0.
- Each axis steps through the phases ACTIVE → FRONT → SYNC → BACK → ACTIVE.
  - Each phase lasts its field value in cycles (horizontal) or lines (vertical).
  - A field value of 0 is treated as 1.
- The horizontal counter advances every cycle. The vertical counter advances once per line, on the last cycle of horizontal BACK.
- Shadow copies of the eight timing fields are loaded in two cases:
  - on the cycle enable goes 0→1;
  - on the last cycle of a frame (last cycle of horizontal BACK in the last vertical BACK line).
- Register changes mid-frame have no effect until the next frame.
- hblank = horizontal phase ≠ ACTIVE. vblank = vertical phase ≠ ACTIVE.
- hsync = horizontal phase SYNC. vsync = vertical phase SYNC.
- Active pixel = both phases ACTIVE. On an active pixel:
  - fifo_rd = ~fifo_empty.
  - If not empty, {R,G,B} ← fifo_data.
  - If empty, {R,G,B} ← 0 and underrun ← 1.
- On a non-active pixel: fifo_rd = 0 and {R,G,B} ← 0.
- underrun clears only on reset or while enable = 0.
- enable = 0 behaviour:
  - counters held at (ACTIVE, 0) on both axes;
  - outputs take their reset values; no FIFO reads;
  - deasserting enable mid-frame aborts the frame immediately.
- Counter arithmetic:
  - unsigned CW bits;
  - phase ends when count == field−1, then count resets to 0;
  - no wrap beyond field length is possible.

## Timing
- One-cycle latency: the counter state in cycle n produces hsync/hblank/vsync/vblank/RGB/frame_start/line_done at edge n+1. All of them are mutually aligned.
- fifo_rd is asserted in cycle n, the same cycle fifo_data is sampled. The FIFO pointer advances at edge n+1.
- Line period = hactive+hfront+hsync+hback cycles.
- Frame period = line period × (vactive+vfront+vsync+vback).
- The first frame after enable starts at horizontal ACTIVE, line 0. The first pixel is presented one cycle after enable is sampled high.
- Reset asserted mid-frame forces the reset values asynchronously. Operation restarts at (ACTIVE, 0) on the first edge after release, if enable = 1.

## Structure
- Package vid_pkg holds:
  - typedef enum phase_t {PH_ACTIVE, PH_FRONT, PH_SYNC, PH_BACK};
  - field bit-position constants for h1/h2/v1/v2;
  - CR_ENABLE_BIT = 0.
- Sub-module vid_axis_counter, instantiated twice (horizontal and vertical):
  - inputs: advance, the four phase lengths, clear;
  - outputs: phase, count, last (final step of BACK).

## Test plan
- Timing check:
  - stimulus: h=(4,1,2,1), v=(3,1,1,1), enable=1, FIFO always non-empty;
  - required: 8-cycle lines and 48-cycle frames;
  - hsync high for cycles 5–6 of each line; vsync high on line 4;
  - exactly 12 fifo_rd per frame; frame_start once per 48 cycles.
- Pixel data:
  - stimulus: same timing, FIFO words 0x010203, 0x040506, ...;
  - required: R/G/B present them in order, only while hblank=vblank=0, aligned to the blanking outputs;
  - line_done pulses with the 4th pixel of lines 0–2.
- Underrun:
  - stimulus: fifo_empty=1 during pixel 2 of line 1;
  - required: RGB=0 for that pixel, no fifo_rd, underrun=1 and sticky until enable is dropped.
- Mid-frame reprogram:
  - stimulus: change hactive 4→6 during line 1;
  - required: the current frame keeps 8-cycle lines; the next frame uses 10-cycle lines.
- Abort:
  - stimulus: drop enable at line 2; separately, assert reset mid-line;
  - required: outputs return to reset values (hblank=vblank=1, RGB=0);
  - after re-enable, the frame restarts at line 0, pixel 0.
- Zero fields:
  - stimulus: hfront=0, vsync=0;
  - required: each is treated as a 1-cycle / 1-line phase.
